wb_pipe_arbiter: RTL and testbench

- Shares the single Wishbone master port of the bexkat1 core between two requesters:
  - the instruction-fetch port (read-only);
  - the data port (loads and stores computed by the execute stage).
- Grant selection is a registered state machine, with the data side preferred and alternating priority on ties.
- A bus-timeout counter converts a hung slave into a one-cycle error pulse to the owning requester, so the pipeline can take a bus-error exception.

---
 rtl/wb_pipe_arbiter.sv | 176 +++++++++++++++++
 tb/tb_wb_pipe_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_arbiter.sv
// rtl/wb_pipe_arbiter.sv - Wishbone master-port arbiter for fetch and data requesters with bus timeout
module wb_pipe_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          inst_cyc_i,
    input  logic          inst_stb_i,
    input  logic [AW-1:0] inst_adr_i,
    output logic [DW-1:0] inst_dat_o,
    output logic          inst_ack_o,
    output logic          inst_err_o,

    input  logic          data_cyc_i,
    input  logic          data_stb_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_sel_i,
    input  logic [AW-1:0] data_adr_i,
    input  logic [DW-1:0] data_dat_i,
    output logic [DW-1:0] data_dat_o,
    output logic          data_ack_o,
    output logic          data_err_o,

    output logic          bus_cyc_o,
    output logic          bus_stb_o,
    output logic          bus_we_o,
    output logic [3:0]    bus_sel_o,
    output logic [AW-1:0] bus_adr_o,
    output logic [DW-1:0] bus_dat_o,
    input  logic [DW-1:0] bus_dat_i,
    input  logic          bus_ack_i,
    input  logic          bus_err_i,

    output logic [1:0]    grant_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INST = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    localparam logic       OWN_INST    = 1'b0;
    localparam logic       OWN_DATA    = 1'b1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic        force_idle_q, force_idle_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        owner_cyc;
    logic        owner_stb;
    logic        timeout_hit;
    logic        inst_owns;
    logic        data_owns;

    assign inst_owns = (state_q == ST_INST);
    assign data_owns = (state_q == ST_DATA);

    // Steer the owner's request onto the shared master port; fetches are always full-word reads
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        bus_we_o  = 1'b0;
        bus_sel_o = 4'h0;
        bus_adr_o = '0;
        bus_dat_o = '0;
        case (state_q)
            ST_INST: begin
                owner_cyc = inst_cyc_i;
                owner_stb = inst_stb_i;
                bus_sel_o = 4'hF;
                bus_adr_o = inst_adr_i;
            end
            ST_DATA: begin
                owner_cyc = data_cyc_i;
                owner_stb = data_stb_i;
                bus_we_o  = data_we_i;
                bus_sel_o = data_sel_i;
                bus_adr_o = data_adr_i;
                bus_dat_o = data_dat_i;
            end
            default: begin
            end
        endcase
    end

    assign bus_cyc_o = owner_cyc & ~force_idle_q;
    assign bus_stb_o = owner_stb & ~force_idle_q;

    // A strobe left unanswered for TIMEOUT cycles is turned into an error; a real ack or err wins
    assign timeout_hit = (wait_cnt_q == TIMEOUT_CNT) & bus_stb_o & ~bus_ack_i & ~bus_err_i;

    assign inst_dat_o = bus_dat_i;
    assign data_dat_o = bus_dat_i;
    assign inst_ack_o = inst_owns & bus_ack_i;
    assign data_ack_o = data_owns & bus_ack_i;
    assign inst_err_o = inst_owns & (bus_err_i | timeout_hit);
    assign data_err_o = data_owns & (bus_err_i | timeout_hit);

    assign grant_o = state_q;
    assign busy_o  = (state_q != ST_IDLE);

    // Grant selection: data preferred on a tie unless it owned the bus last; direct handover on release
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        force_idle_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The cycle after a timeout is a dead cycle; arbitration waits one more cycle
                if (!force_idle_q) begin
                    if (data_cyc_i && inst_cyc_i) begin
                        state_d = (last_owner_q == OWN_INST) ? ST_DATA : ST_INST;
                    end else if (data_cyc_i) begin
                        state_d = ST_DATA;
                    end else if (inst_cyc_i) begin
                        state_d = ST_INST;
                    end
                end
            end
            ST_INST: begin
                if (timeout_hit) begin
                    state_d      = ST_IDLE;
                    force_idle_d = 1'b1;
                    last_owner_d = OWN_INST;
                end else if (!inst_cyc_i) begin
                    state_d      = data_cyc_i ? ST_DATA : ST_IDLE;
                    last_owner_d = OWN_INST;
                end
            end
            ST_DATA: begin
                if (timeout_hit) begin
                    state_d      = ST_IDLE;
                    force_idle_d = 1'b1;
                    last_owner_d = OWN_DATA;
                end else if (!data_cyc_i) begin
                    state_d      = inst_cyc_i ? ST_INST : ST_IDLE;
                    last_owner_d = OWN_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Count consecutive strobed, unanswered cycles for the current owner
    always_comb begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if ((state_d != state_q) || !bus_stb_o || bus_ack_i || bus_err_i) begin
            wait_cnt_d = 8'd0;
        end
    end

    // State, arbitration history, dead-cycle flag and wait counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_INST;
            force_idle_q <= 1'b0;
            wait_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            force_idle_q <= force_idle_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_pipe_arbiter.sv
// tb/tb_wb_pipe_arbiter.sv - directed self-checking bench for wb_pipe_arbiter
module tb_wb_pipe_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 6;

    logic          clk_i;
    logic          rst_i;
    logic          inst_cyc_i;
    logic          inst_stb_i;
    logic [AW-1:0] inst_adr_i;
    logic [DW-1:0] inst_dat_o;
    logic          inst_ack_o;
    logic          inst_err_o;
    logic          data_cyc_i;
    logic          data_stb_i;
    logic          data_we_i;
    logic [3:0]    data_sel_i;
    logic [AW-1:0] data_adr_i;
    logic [DW-1:0] data_dat_i;
    logic [DW-1:0] data_dat_o;
    logic          data_ack_o;
    logic          data_err_o;
    logic          bus_cyc_o;
    logic          bus_stb_o;
    logic          bus_we_o;
    logic [3:0]    bus_sel_o;
    logic [AW-1:0] bus_adr_o;
    logic [DW-1:0] bus_dat_o;
    logic [DW-1:0] bus_dat_i;
    logic          bus_ack_i;
    logic          bus_err_i;
    logic [1:0]    grant_o;
    logic          busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int errs;

    wb_pipe_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_cyc_i(inst_cyc_i), .inst_stb_i(inst_stb_i), .inst_adr_i(inst_adr_i),
        .inst_dat_o(inst_dat_o), .inst_ack_o(inst_ack_o), .inst_err_o(inst_err_o),
        .data_cyc_i(data_cyc_i), .data_stb_i(data_stb_i), .data_we_i(data_we_i),
        .data_sel_i(data_sel_i), .data_adr_i(data_adr_i), .data_dat_i(data_dat_i),
        .data_dat_o(data_dat_o), .data_ack_o(data_ack_o), .data_err_o(data_err_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        inst_cyc_i = 0; inst_stb_i = 0; inst_adr_i = '0;
        data_cyc_i = 0; data_stb_i = 0; data_we_i = 0; data_sel_i = 4'h0;
        data_adr_i = '0; data_dat_i = '0;
        bus_dat_i = '0; bus_ack_i = 0; bus_err_i = 0;
        step();
        step();
        settle();
        check("rst_grant", grant_o, 2'b00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_cyc", bus_cyc_o, 1'b0);
        check("rst_stb", bus_stb_o, 1'b0);
        check("rst_sel", bus_sel_o, 4'h0);
        check("rst_adr", bus_adr_o, 32'h0);
        step();
        rst_i = 1'b0;

        // fetch read acked two cycles after the first strobed cycle
        step();
        inst_cyc_i = 1; inst_stb_i = 1; inst_adr_i = 32'h100;
        settle();
        check("t1_req_grant", grant_o, 2'b00);
        check("t1_req_cyc", bus_cyc_o, 1'b0);
        step();
        settle();
        check("t1_grant", grant_o, 2'b01);
        check("t1_adr", bus_adr_o, 32'h100);
        check("t1_stb", bus_stb_o, 1'b1);
        check("t1_sel", bus_sel_o, 4'hF);
        check("t1_we", bus_we_o, 1'b0);
        check("t1_busy", busy_o, 1'b1);
        step();
        settle();
        check("t1_wait_ack", inst_ack_o, 1'b0);
        step();
        bus_ack_i = 1; bus_dat_i = 32'hDEADBEEF;
        settle();
        check("t1_ack", inst_ack_o, 1'b1);
        check("t1_dat", inst_dat_o, 32'hDEADBEEF);
        check("t1_data_ack", data_ack_o, 1'b0);
        check("t1_data_dat", data_dat_o, 32'hDEADBEEF);
        step();
        bus_ack_i = 0; inst_cyc_i = 0; inst_stb_i = 0;
        settle();
        check("t1_rel_grant", grant_o, 2'b01);
        check("t1_rel_cyc", bus_cyc_o, 1'b0);
        step();
        settle();
        check("t1_idle", grant_o, 2'b00);

        // ties and direct handover
        step();
        inst_cyc_i = 1; inst_stb_i = 1; data_cyc_i = 1; data_stb_i = 1; data_adr_i = 32'h300;
        settle();
        step();
        settle();
        check("t2_tie1", grant_o, 2'b10);
        check("t2_tie1_adr", bus_adr_o, 32'h300);
        step();
        data_cyc_i = 0; data_stb_i = 0;
        settle();
        check("t2_rel_hold", grant_o, 2'b10);
        check("t2_inst_noack", inst_ack_o, 1'b0);
        step();
        settle();
        check("t2_handover", grant_o, 2'b01);
        check("t2_handover_adr", bus_adr_o, 32'h100);
        step();
        inst_cyc_i = 0; inst_stb_i = 0;
        settle();
        step();
        settle();
        check("t2_idle1", grant_o, 2'b00);
        step();
        inst_cyc_i = 1; inst_stb_i = 1; data_cyc_i = 1; data_stb_i = 1;
        settle();
        step();
        settle();
        check("t2_tie2", grant_o, 2'b10);
        step();
        inst_cyc_i = 0; inst_stb_i = 0; data_cyc_i = 0; data_stb_i = 0;
        settle();
        step();
        settle();
        check("t2_idle2", grant_o, 2'b00);
        step();
        inst_cyc_i = 1; inst_stb_i = 1; data_cyc_i = 1; data_stb_i = 1;
        settle();
        step();
        settle();
        check("t2_tie3", grant_o, 2'b01);
        step();
        inst_cyc_i = 0; inst_stb_i = 0; data_cyc_i = 0; data_stb_i = 0;
        settle();
        step();
        settle();
        check("t2_idle3", grant_o, 2'b00);

        // three-beat store with strobe gaps
        step();
        data_cyc_i = 1; data_stb_i = 1; data_we_i = 1; data_sel_i = 4'b0011;
        data_adr_i = 32'h2000; data_dat_i = 32'h1234;
        settle();
        for (int b = 0; b < 3; b++) begin
            step();
            bus_ack_i = 1; data_stb_i = 1;
            settle();
            check("t3_we", bus_we_o, 1'b1);
            check("t3_sel", bus_sel_o, 4'h3);
            check("t3_adr", bus_adr_o, 32'h2000);
            check("t3_wdat", bus_dat_o, 32'h1234);
            check("t3_ack", data_ack_o, 1'b1);
            check("t3_inst_ack", inst_ack_o, 1'b0);
            step();
            bus_ack_i = 0; data_stb_i = 0;
            settle();
            check("t3_gap_grant", grant_o, 2'b10);
            check("t3_gap_stb", bus_stb_o, 1'b0);
            check("t3_gap_cyc", bus_cyc_o, 1'b1);
        end
        step();
        data_cyc_i = 0; data_we_i = 0; data_sel_i = 4'h0; data_dat_i = '0;
        settle();
        step();
        settle();
        check("t3_idle", grant_o, 2'b00);

        // hung slave: timeout error, dead cycle, then re-grant
        step();
        data_cyc_i = 1; data_stb_i = 1; data_adr_i = 32'h4000;
        settle();
        step();
        settle();
        check("t4_grant", grant_o, 2'b10);
        errs = 0;
        if (data_err_o) errs++;
        for (int k = 1; k < TO; k++) begin
            step();
            settle();
            if (data_err_o) errs++;
        end
        check("t4_no_early_err", errs, 0);
        step();
        settle();
        check("t4_err", data_err_o, 1'b1);
        check("t4_inst_err", inst_err_o, 1'b0);
        check("t4_ack", data_ack_o, 1'b0);
        step();
        settle();
        check("t4_dead_cyc", bus_cyc_o, 1'b0);
        check("t4_dead_grant", grant_o, 2'b00);
        check("t4_dead_err", data_err_o, 1'b0);
        step();
        settle();
        check("t4_arb_grant", grant_o, 2'b00);
        step();
        settle();
        check("t4_regrant", grant_o, 2'b10);
        check("t4_regrant_stb", bus_stb_o, 1'b1);

        // ack arriving on the timeout cycle takes priority
        for (int k = 1; k < TO; k++) begin
            step();
            settle();
        end
        step();
        bus_ack_i = 1;
        settle();
        check("t5_ack", data_ack_o, 1'b1);
        check("t5_err", data_err_o, 1'b0);
        step();
        bus_ack_i = 0; data_cyc_i = 0; data_stb_i = 0;
        settle();
        check("t5_hold", grant_o, 2'b10);
        check("t5_no_err", data_err_o, 1'b0);
        step();
        settle();
        check("t5_idle", grant_o, 2'b00);

        // reset in the middle of a fetch that is being acked
        step();
        inst_cyc_i = 1; inst_stb_i = 1; inst_adr_i = 32'h600;
        settle();
        step();
        settle();
        check("t6_grant", grant_o, 2'b01);
        step();
        bus_ack_i = 1; rst_i = 1;
        #1;
        check("t6_ack", inst_ack_o, 1'b0);
        check("t6_cyc", bus_cyc_o, 1'b0);
        check("t6_stb", bus_stb_o, 1'b0);
        check("t6_adr", bus_adr_o, 32'h0);
        check("t6_sel", bus_sel_o, 4'h0);
        check("t6_rst_grant", grant_o, 2'b00);
        step();
        rst_i = 0; bus_ack_i = 0; data_cyc_i = 1; data_stb_i = 1;
        settle();
        check("t6_post_idle", grant_o, 2'b00);
        step();
        settle();
        check("t6_tie", grant_o, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
